// File: rtl/move_link_receiver.sv
// Receive end of the inter-board move link.
// Recovers FRAME_BITS-wide column moves shifted in MSB-first on an
// asynchronous link clock. Each bit is qualified by the peer's ready line.
// Frames are buffered in a small FIFO. The FIFO is presented to the Nios PIO
// as a valid/accept head, plus a toggle line that inverts on every committed
// frame.
module move_link_receiver #(
  parameter int FRAME_BITS     = 4,
  parameter int FIFO_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                  clock,
  input  logic                  reset_active_low,
  input  logic                  link_clock,
  input  logic                  RX_data,
  input  logic                  RX_ready,
  input  logic                  enable,
  output logic [FRAME_BITS-1:0] move_data,
  output logic                  move_valid,
  input  logic                  move_accept,
  output logic                  move_toggle,
  output logic [2:0]            bits_pending,
  output logic                  overflow,
  output logic                  frame_error,
  input  logic                  clear_errors
);

  localparam int            AW         = $clog2(FIFO_DEPTH);
  localparam int            TW         = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    LAST_BIT   = 3'(FRAME_BITS - 1);

  typedef enum logic {IDLE, RECV} state_t;

  // Internal reset: asserts immediately with the pin and releases two clocks
  // after the pin releases, so no flop sees a release close to a clock edge.
  logic rst_meta;
  logic rst_n;

  // Reset synchronizer.
  always_ff @(posedge clock or negedge reset_active_low) begin
    if (!reset_active_low) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  // Bit [0] is the metastability flop, [1] the synced value, [2] the history.
  logic [2:0] link_sync;
  logic [2:0] data_sync;
  logic [2:0] ready_sync;

  // Two-flop synchronizers plus one history stage on all link inputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      link_sync  <= '0;
      data_sync  <= '0;
      ready_sync <= '0;
    end else begin
      link_sync  <= {link_sync[1:0], link_clock};
      data_sync  <= {data_sync[1:0], RX_data};
      ready_sync <= {ready_sync[1:0], RX_ready};
    end
  end

  // Data and ready are taken from the history stage. These are the values
  // held just before the edge, so the peer's post-edge update cannot race
  // the sample.
  logic link_edge;
  logic data_bit;
  logic ready_bit;
  assign link_edge = link_sync[1] & ~link_sync[2];
  assign data_bit  = data_sync[2];
  assign ready_bit = ready_sync[2];

  state_t                state;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [FRAME_BITS:0]   shift_wide;
  logic [TW-1:0]         timer;
  logic                  push_req;
  logic [FRAME_BITS-1:0] push_data;

  assign shift_wide = {shift_reg, data_bit};

  // Frame assembly FSM. It handles bit shifting, framing errors and the
  // mid-frame timeout. It produces a one-cycle push request for the FIFO.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shift_reg    <= '0;
      bits_pending <= '0;
      timer        <= '0;
      push_req     <= 1'b0;
      push_data    <= '0;
      frame_error  <= 1'b0;
    end else begin
      push_req <= 1'b0;
      // A clear is overridden by an error event later in this block.
      if (clear_errors) frame_error <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (enable && link_edge && ready_bit) begin
            if (LAST_BIT == 3'd0) begin
              push_req  <= 1'b1;
              push_data <= shift_wide[FRAME_BITS-1:0];
              shift_reg <= '0;
            end else begin
              shift_reg    <= shift_wide[FRAME_BITS-1:0];
              bits_pending <= 3'd1;
              state        <= RECV;
            end
          end
        end
        RECV: begin
          if (!enable) begin
            shift_reg    <= '0;
            bits_pending <= '0;
            timer        <= '0;
            state        <= IDLE;
          end else if (link_edge && ready_bit) begin
            timer <= '0;
            if (bits_pending == LAST_BIT) begin
              push_req     <= 1'b1;
              push_data    <= shift_wide[FRAME_BITS-1:0];
              shift_reg    <= '0;
              bits_pending <= '0;
              state        <= IDLE;
            end else begin
              shift_reg    <= shift_wide[FRAME_BITS-1:0];
              bits_pending <= bits_pending + 3'd1;
            end
          end else if (link_edge || (timer == TIMER_LAST)) begin
            frame_error  <= 1'b1;
            shift_reg    <= '0;
            bits_pending <= '0;
            timer        <= '0;
            state        <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
      endcase
    end
  end

  logic [FRAME_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [AW:0]           wr_next;
  logic [AW:0]           rd_next;
  logic                  full;
  logic                  do_pop;
  logic                  do_push;
  logic                  drop;
  logic [FRAME_BITS-1:0] head_next;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = move_valid && move_accept;
  assign do_push = push_req && (!full || do_pop);
  assign drop    = push_req && full && !do_pop;

  // Next pointers and next head value. The head is registered, so the PIO
  // never sees a combinational path from the link or from move_accept.
  always_comb begin
    rd_next   = rd_ptr + (AW + 1)'(do_pop);
    wr_next   = wr_ptr + (AW + 1)'(do_push);
    head_next = '0;
    if (rd_next != wr_next) begin
      if (do_push && (rd_next == wr_ptr)) head_next = push_data;
      else                                head_next = mem[rd_next[AW-1:0]];
    end
  end

  // FIFO storage, pointers, head register, toggle and overflow flag.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      move_data   <= '0;
      move_valid  <= 1'b0;
      move_toggle <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
      wr_ptr      <= wr_next;
      rd_ptr      <= rd_next;
      move_data   <= head_next;
      move_valid  <= (rd_next != wr_next);
      move_toggle <= move_toggle ^ do_push;
      if (drop)              overflow <= 1'b1;
      else if (clear_errors) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_move_link_receiver.sv
// Directed and randomized bench for move_link_receiver. A frame-level model
// tracks the expected queue contents, toggle count, pending bits and sticky
// flags.
module tb_move_link_receiver;

  localparam int FB    = 4;
  localparam int DEPTH = 2;
  localparam int TO    = 64;

  logic          clock = 1'b0;
  logic          reset_active_low = 1'b0;
  logic          link_clock = 1'b0;
  logic          RX_data = 1'b0;
  logic          RX_ready = 1'b0;
  logic          enable = 1'b1;
  logic [FB-1:0] move_data;
  logic          move_valid;
  logic          move_accept = 1'b0;
  logic          move_toggle;
  logic [2:0]    bits_pending;
  logic          overflow;
  logic          frame_error;
  logic          clear_errors = 1'b0;

  move_link_receiver #(.FRAME_BITS(FB), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_active_low(reset_active_low), .link_clock(link_clock),
    .RX_data(RX_data), .RX_ready(RX_ready), .enable(enable),
    .move_data(move_data), .move_valid(move_valid), .move_accept(move_accept),
    .move_toggle(move_toggle), .bits_pending(bits_pending), .overflow(overflow),
    .frame_error(frame_error), .clear_errors(clear_errors)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int q[$];
  int pend = 0;
  int part = 0;
  int ovf  = 0;
  int ferr = 0;
  int tog  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_valid"},   32'(move_valid),   32'(q.size() > 0));
    chk({tag, "_data"},    32'(move_data),    (q.size() > 0) ? 32'(q[0]) : 32'd0);
    chk({tag, "_toggle"},  32'(move_toggle),  32'(tog));
    chk({tag, "_pending"}, 32'(bits_pending), 32'(pend));
    chk({tag, "_ovf"},     32'(overflow),     32'(ovf));
    chk({tag, "_ferr"},    32'(frame_error),  32'(ferr));
  endtask

  task automatic model_push(input int v);
    if (q.size() == DEPTH) ovf = 1;
    else begin
      q.push_back(v);
      tog ^= 1;
    end
  endtask

  task automatic model_bit(input bit rdy, input bit d);
    if (!rdy) begin
      if (pend > 0) ferr = 1;
      pend = 0;
      part = 0;
    end else begin
      part = (part * 2 + int'(d)) % (1 << FB);
      pend++;
      if (pend == FB) begin
        model_push(part);
        pend = 0;
        part = 0;
      end
    end
  endtask

  task automatic model_reset();
    q.delete();
    pend = 0; part = 0; ovf = 0; ferr = 0; tog = 0;
  endtask

  // One link bit: low phase with data/ready set up, then a rising link edge.
  // clr raises clear_errors in the cycle the bit is processed. acc raises
  // move_accept in the cycle that bit's frame would be pushed.
  task automatic send_bit(input bit rdy, input bit d, input bit clr, input bit acc);
    @(negedge clock);
    link_clock = 1'b0; RX_data = d; RX_ready = rdy;
    repeat (3) @(negedge clock);
    link_clock = 1'b1;
    @(negedge clock);
    @(negedge clock);
    if (clr) clear_errors = 1'b1;
    @(negedge clock);
    clear_errors = 1'b0;
    if (acc) begin
      move_accept = 1'b1;
      @(negedge clock);
      move_accept = 1'b0;
    end
    if (clr) begin ovf = 0; ferr = 0; end
    if (acc && q.size() > 0) void'(q.pop_front());
    model_bit(rdy, d);
  endtask

  task automatic send_frame(input int v, input bit acc);
    for (int i = FB - 1; i >= 0; i--) send_bit(1'b1, v[i], 1'b0, acc && (i == 0));
    repeat (2) @(negedge clock);
  endtask

  task automatic accept_pulse();
    @(negedge clock);
    move_accept = 1'b1;
    @(negedge clock);
    move_accept = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic clear_pulse();
    @(negedge clock);
    clear_errors = 1'b1;
    @(negedge clock);
    clear_errors = 1'b0;
    ovf = 0; ferr = 0;
  endtask

  initial begin
    int v;
    // Reset state
    #23;
    compare_all("reset");
    @(negedge clock);
    reset_active_low = 1'b1;
    repeat (5) @(negedge clock);
    compare_all("post_reset");

    // Basic frame 0110
    send_frame(6, 1'b0);
    compare_all("basic");
    chk("basic_toggle_rose", 32'(move_toggle), 32'd1);
    accept_pulse();
    compare_all("basic_pop");

    // Back-to-back into a full FIFO
    send_frame(3, 1'b0);
    send_frame(5, 1'b0);
    send_frame(7, 1'b0);
    compare_all("full");
    accept_pulse();
    compare_all("full_pop1");
    accept_pulse();
    compare_all("full_pop2");
    clear_pulse();
    compare_all("full_clear");

    // Simultaneous push and pop while full
    send_frame(1, 1'b0);
    send_frame(2, 1'b0);
    compare_all("simul_pre");
    send_frame(4, 1'b1);
    compare_all("simul");
    accept_pulse();
    compare_all("simul_pop1");
    accept_pulse();
    compare_all("simul_pop2");

    // Mid-frame gap then a clean frame
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0, 1'b0);
    compare_all("gap");
    send_frame(8, 1'b0);
    compare_all("after_gap");
    accept_pulse();
    clear_pulse();
    compare_all("gap_clear");

    // Timeout after one bit, then clear
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (50) @(negedge clock);
    compare_all("timeout_wait");
    repeat (20) @(negedge clock);
    pend = 0; part = 0; ferr = 1;
    compare_all("timeout");
    clear_pulse();
    compare_all("timeout_clear");
    // Clear coinciding with a new gap: the error wins
    send_bit(1'b1, 1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b1, 1'b0);
    compare_all("clear_vs_gap");
    clear_pulse();

    // Enable dropped mid-frame
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    compare_all("en_pending");
    @(negedge clock);
    enable = 1'b0;
    repeat (3) @(negedge clock);
    pend = 0; part = 0;
    compare_all("en_drop");
    enable = 1'b1;

    // Randomized frames with random accepts
    for (int it = 0; it < 10; it++) begin
      v = int'($urandom_range(0, (1 << FB) - 1));
      send_frame(v, 1'($urandom_range(0, 1)));
      compare_all("rand_push");
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) accept_pulse();
      compare_all("rand_pop");
    end
    clear_pulse();
    while (q.size() > 0) accept_pulse();
    compare_all("rand_drain");

    // Asynchronous reset with one frame buffered and two bits pending
    send_frame(int'($urandom_range(0, (1 << FB) - 1)), 1'b0);
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    compare_all("pre_async_reset");
    @(negedge clock);
    #2;
    reset_active_low = 1'b0;
    link_clock = 1'b0; RX_ready = 1'b0; RX_data = 1'b0;
    #1;
    model_reset();
    compare_all("async_reset");
    @(negedge clock);
    reset_active_low = 1'b1;
    repeat (5) @(negedge clock);
    compare_all("reset_release");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
